// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC/argmax scoring sequencer.
package mac_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_MUL,
      S_ADD,
      S_BRD,
      S_BIAS,
      S_CMP,
      S_DONE
   } state_e;

   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;

   localparam logic [31:0] FP_ZERO = 32'h0;

endpackage

// File: rtl/argmax_tracker.sv
// Running maximum / index of class scores; publishes the winner on commit.
module argmax_tracker
   import mac_pkg::*;
#(
   parameter int M  = 2,
   parameter int AW = 18
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          upd_en,
   input  logic          first,
   input  logic          sub_neg,
   input  logic [31:0]   score,
   input  logic [AW-1:0] j,
   input  logic          commit,
   output logic [31:0]   max_val,
   output logic [AW-1:0] class_idx,
   output logic [M-1:0]  class_onehot
);

   logic [31:0]   max_q, max_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW-1:0] cls_q, cls_d;
   logic [M-1:0]  oh_q, oh_d;
   logic          take;

   // A non-negative difference (including +0) means the newer score wins.
   assign take = upd_en & (first | ~sub_neg);

   always_comb begin
      max_d = max_q;
      idx_d = idx_q;
      cls_d = cls_q;
      oh_d  = oh_q;
      if (take) begin
         max_d = score;
         idx_d = j;
      end
      if (commit) begin
         cls_d = idx_q;
         for (int k = 0; k < M; k++) begin
            oh_d[k] = (idx_q == AW'(k));
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         max_q <= FP_ZERO;
         idx_q <= '0;
         cls_q <= '0;
         oh_q  <= '0;
      end else begin
         max_q <= max_d;
         idx_q <= idx_d;
         cls_q <= cls_d;
         oh_q  <= oh_d;
      end
   end

   assign max_val      = max_q;
   assign class_idx    = cls_q;
   assign class_onehot = oh_q;

endmodule

// File: rtl/mac_argmax_sched.sv
// Sequences x*W+b scoring over a shared FP unit and picks the argmax class.
module mac_argmax_sched
   import mac_pkg::*;
#(
   parameter int N  = 3,
   parameter int M  = 2,
   parameter int AW = 18
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] x_addr,
   output logic [AW-1:0] w_addr,
   output logic [AW-1:0] b_addr,
   input  logic [31:0]   x_data,
   input  logic [31:0]   w_data,
   input  logic [31:0]   b_data,
   output logic          fpu_req,
   output logic [1:0]    fpu_op,
   output logic [31:0]   fpu_a,
   output logic [31:0]   fpu_b,
   input  logic          fpu_ack,
   input  logic [31:0]   fpu_res,
   output logic [AW-1:0] class_idx,
   output logic [M-1:0]  class_onehot
);

   localparam logic [AW-1:0] N_LAST = AW'(N - 1);
   localparam logic [AW-1:0] M_LAST = AW'(M - 1);
   localparam logic [AW-1:0] M_AW   = AW'(M);
   localparam logic [AW-1:0] ONE    = AW'(1);

   state_e        state_q, state_d;
   logic [AW-1:0] i_q, i_d, j_q, j_d;
   logic [AW-1:0] xa_q, xa_d, wa_q, wa_d, ba_q, ba_d;
   logic [31:0]   acc_q, acc_d, prod_q, prod_d;
   logic [31:0]   score_q, score_d;
   logic [31:0]   opa_q, opa_d, opb_q, opb_d;
   logic          cap_q, cap_d;
   logic          busy_q, busy_d, done_q, done_d;
   logic          upd_en, commit;
   logic [31:0]   max_val;

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      xa_d    = xa_q;
      wa_d    = wa_q;
      ba_d    = ba_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
      score_d = score_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      cap_d   = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      fpu_req = 1'b0;
      fpu_op  = OP_MUL;
      fpu_a   = FP_ZERO;
      fpu_b   = FP_ZERO;
      upd_en  = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start && !done_q) begin
               i_d     = '0;
               j_d     = '0;
               acc_d   = FP_ZERO;
               busy_d  = 1'b1;
               state_d = S_RD;
            end
         end
         S_RD: begin
            xa_d    = i_q;
            wa_d    = i_q * M_AW + j_q;
            cap_d   = 1'b1;
            state_d = S_MUL;
         end
         S_MUL: begin
            // Read data lands this cycle; latch it so waits see it unchanged.
            fpu_req = 1'b1;
            fpu_op  = OP_MUL;
            fpu_a   = cap_q ? x_data : opa_q;
            fpu_b   = cap_q ? w_data : opb_q;
            opa_d   = fpu_a;
            opb_d   = fpu_b;
            if (fpu_ack) begin
               prod_d  = fpu_res;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            fpu_req = 1'b1;
            fpu_op  = OP_ADD;
            fpu_a   = acc_q;
            fpu_b   = prod_q;
            if (fpu_ack) begin
               acc_d = fpu_res;
               if (i_q == N_LAST) begin
                  state_d = S_BRD;
               end else begin
                  i_d     = i_q + ONE;
                  state_d = S_RD;
               end
            end
         end
         S_BRD: begin
            ba_d    = j_q;
            cap_d   = 1'b1;
            state_d = S_BIAS;
         end
         S_BIAS: begin
            fpu_req = 1'b1;
            fpu_op  = OP_ADD;
            fpu_a   = acc_q;
            fpu_b   = cap_q ? b_data : opb_q;
            opb_d   = fpu_b;
            if (fpu_ack) begin
               score_d = fpu_res;
               state_d = S_CMP;
            end
         end
         S_CMP: begin
            if (j_q != '0) begin
               fpu_req = 1'b1;
               fpu_op  = OP_SUB;
               fpu_a   = score_q;
               fpu_b   = max_val;
            end
            if (j_q == '0 || fpu_ack) begin
               upd_en = 1'b1;
               if (j_q == M_LAST) begin
                  state_d = S_DONE;
               end else begin
                  j_d     = j_q + ONE;
                  i_d     = '0;
                  acc_d   = FP_ZERO;
                  state_d = S_RD;
               end
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            commit  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         xa_q    <= '0;
         wa_q    <= '0;
         ba_q    <= '0;
         acc_q   <= FP_ZERO;
         prod_q  <= FP_ZERO;
         score_q <= FP_ZERO;
         opa_q   <= FP_ZERO;
         opb_q   <= FP_ZERO;
         cap_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         xa_q    <= xa_d;
         wa_q    <= wa_d;
         ba_q    <= ba_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
         score_q <= score_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         cap_q   <= cap_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign x_addr = xa_d;
   assign w_addr = wa_d;
   assign b_addr = ba_d;
   assign busy   = busy_q;
   assign done   = done_q;

   argmax_tracker #(
      .M  (M),
      .AW (AW)
   ) u_track (
      .clk          (clk),
      .reset        (reset),
      .upd_en       (upd_en),
      .first        (j_q == '0),
      .sub_neg      (fpu_res[31]),
      .score        (score_q),
      .j            (j_q),
      .commit       (commit),
      .max_val      (max_val),
      .class_idx    (class_idx),
      .class_onehot (class_onehot)
   );

endmodule
